// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_sched_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STROBE      = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: first set req bit after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the winner.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int j;

  // Scan offsets from farthest to nearest so the nearest requester after ptr wins last.
  always_comb begin
    oh  = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int off = N; off >= 1; off--) begin
      j = (int'(ptr) + off) % N;
      if (req[j]) begin
        oh    = '0;
        oh[j] = 1'b1;
        idx   = IW'(j);
        vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates N_REQ byte senders onto one UART load port, round-robin.
// Latency: txclk one cycle after an IDLE grant decision; ack one cycle after txready returns.
// Backpressure: waits in IDLE while txready=0; gives up with err if the UART never takes the byte.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               hwclk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic               busy,
  output logic [7:0]         txdata,
  output logic               txclk,
  input  logic               txready
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  sched_state_t   state, state_nx;
  logic [7:0]     txdata_nx;
  logic           txclk_nx, err_nx;
  logic [N_REQ-1:0] grant_nx, ack_nx;
  logic [CW-1:0]  cnt, cnt_nx, cnt_inc;
  logic [IW-1:0]  ptr, ptr_nx, widx, widx_nx;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_vld;

  rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .oh  (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign busy    = (state != IDLE);
  assign cnt_inc = cnt + CW'(1);

  // Next-state and registered-output decisions; pulses default low each cycle.
  always_comb begin
    state_nx  = state;
    txdata_nx = txdata;
    txclk_nx  = 1'b0;
    grant_nx  = grant;
    ack_nx    = '0;
    err_nx    = 1'b0;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    widx_nx   = widx;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (txready && pick_vld) begin
          txdata_nx = req_data[8*int'(pick_idx) +: 8];
          grant_nx  = pick_oh;
          widx_nx   = pick_idx;
          txclk_nx  = 1'b1;
          state_nx  = STROBE;
        end
      end
      STROBE: begin
        cnt_nx   = '0;
        state_nx = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!txready) begin
          state_nx = WAIT_DONE;
        end else begin
          // Counter stops at TIMEOUT-1, which fits CW bits, so it cannot wrap.
          cnt_nx = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT - 1)) begin
            err_nx   = 1'b1;
            grant_nx = '0;
            ptr_nx   = widx;
            state_nx = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (txready) begin
          ack_nx[widx] = 1'b1;
          grant_nx     = '0;
          ptr_nx       = widx;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset puts requester 0 first in line.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      txdata <= '0;
      txclk  <= 1'b0;
      grant  <= '0;
      ack    <= '0;
      err    <= 1'b0;
      cnt    <= '0;
      ptr    <= IW'(N_REQ - 1);
      widx   <= '0;
    end else begin
      state  <= state_nx;
      txdata <= txdata_nx;
      txclk  <= txclk_nx;
      grant  <= grant_nx;
      ack    <= ack_nx;
      err    <= err_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      widx   <= widx_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with default N_REQ=4, TIMEOUT=16.
module tb_uart_tx_scheduler;

  localparam int T = 16;

  logic        hwclk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [7:0]  txdata;
  logic        txclk;
  logic        txready;

  int total = 0;
  int bad   = 0;

  uart_tx_scheduler dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the load strobe; an expired bound shows up as a failed check.
  task automatic wait_txclk(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (txclk !== 1'b1 && n < 8);
    chk({tag, "_txclk"}, {31'd0, txclk}, 32'd1);
  endtask

  // From the STROBE cycle: UART takes the byte, stays busy 2 cycles, then returns.
  task automatic finish_xfer(input string tag, input int exp);
    tick();
    txready = 1'b0;
    tick();
    tick();
    txready = 1'b1;
    tick();
    chk({tag, "_ack"}, {28'd0, ack}, 32'd1 << exp);
  endtask

  task automatic do_xfer(input string tag, input int exp);
    wait_txclk(tag);
    chk({tag, "_grant"}, {28'd0, grant}, 32'd1 << exp);
    chk({tag, "_data"}, {24'd0, txdata}, 32'h10 + exp);
    finish_xfer(tag, exp);
  endtask

  initial begin
    reset    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    txready  = 1'b1;
    #12;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txclk", {31'd0, txclk}, 32'd0);
    chk("rst_txdata", {24'd0, txdata}, 32'd0);
    chk("rst_ack_err", {27'd0, ack, err}, 32'd0);
    @(negedge hwclk);
    reset = 1'b1;

    // Single request, data 0x41, UART busy for 10 cycles.
    req_data = 32'h0000_0041;
    req      = 4'b0001;
    tick();
    chk("single_txclk", {31'd0, txclk}, 32'd1);
    chk("single_txdata", {24'd0, txdata}, 32'h41);
    chk("single_grant", {28'd0, grant}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("single_txclk_one", {31'd0, txclk}, 32'd0);
    tick();
    txready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("single_wait_ack", {27'd0, ack, err}, 32'd0);
    end
    txready = 1'b1;
    tick();
    chk("single_ack", {28'd0, ack}, 32'd1);
    chk("single_grant_clr", {28'd0, grant}, 32'd0);
    chk("single_busy_clr", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    tick();
    chk("single_ack_one", {28'd0, ack}, 32'd0);
    chk("single_txdata_hold", {24'd0, txdata}, 32'h41);

    // Fresh reset so fairness starts from requester 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_data = 32'h1312_1110;
    req      = 4'b1111;
    do_xfer("fair0", 0);
    do_xfer("fair1", 1);
    do_xfer("fair2", 2);
    do_xfer("fair3", 3);
    do_xfer("fair4", 0);
    do_xfer("fair5", 1);
    do_xfer("fair6", 2);
    do_xfer("fair7", 3);

    // Timeout: UART never drops txready; err after TIMEOUT cycles from STROBE.
    wait_txclk("tmo");
    chk("tmo_grant", {28'd0, grant}, 32'd1);
    for (int k = 1; k < T; k++) begin
      tick();
      chk("tmo_early", {27'd0, ack, err}, 32'd0);
    end
    tick();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_noack", {28'd0, ack}, 32'd0);
    chk("tmo_grant_clr", {28'd0, grant}, 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("tmo_err_one", {31'd0, err}, 32'd0);
    chk("tmo_next_txclk", {31'd0, txclk}, 32'd1);
    chk("tmo_next_grant", {28'd0, grant}, 32'd2);
    finish_xfer("tmo_next", 1);
    req = 4'b0000;
    tick();

    // Busy UART: no strobe until txready returns.
    txready = 1'b0;
    req     = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bsy_hold", {26'd0, txclk, busy, grant}, 32'd0);
    end
    txready = 1'b1;
    tick();
    chk("bsy_txclk", {31'd0, txclk}, 32'd1);
    chk("bsy_grant", {28'd0, grant}, 32'd4);
    chk("bsy_data", {24'd0, txdata}, 32'h12);
    finish_xfer("bsy", 2);
    req = 4'b0000;
    tick();

    // Reset in WAIT_DONE abandons requester 3; requester 0 is served first after.
    req = 4'b1001;
    wait_txclk("rmid");
    chk("rmid_grant", {28'd0, grant}, 32'd8);
    tick();
    txready = 1'b0;
    tick();
    tick();
    chk("rmid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_grant0", {28'd0, grant}, 32'd0);
    chk("rmid_busy0", {31'd0, busy}, 32'd0);
    chk("rmid_txdata0", {24'd0, txdata}, 32'd0);
    chk("rmid_pulses0", {26'd0, txclk, ack, err}, 32'd0);
    tick();
    reset   = 1'b1;
    txready = 1'b1;
    do_xfer("rmid_regrant", 0);
    req = 4'b0000;
    tick();

    // Requester 1 drops req while UART is sending; ack still arrives.
    req = 4'b0010;
    wait_txclk("drop");
    chk("drop_grant", {28'd0, grant}, 32'd2);
    tick();
    txready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    chk("drop_grant_held", {28'd0, grant}, 32'd2);
    txready = 1'b1;
    tick();
    chk("drop_ack", {28'd0, ack}, 32'd2);
    tick();
    chk("drop_idle", {27'd0, busy, ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the UART transmit path (2..8).
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for the UART to take a byte.
REQ-003 hwclk  input  1: the only clock; all state updates on rising edge.
REQ-004 reset  input  1: reset, asynchronous, active-low.
REQ-005 req  input  N_REQ: per-requester send request; held high until the matching ack pulse.
REQ-006 req_data  input  8*N_REQ: byte for requester i at bits [8i+7:8i]; stable while req[i] is high.
REQ-007 grant  output  N_REQ: one-hot, marks the requester currently being served.
REQ-008 ack  output  N_REQ: one-cycle pulse, byte of requester i fully sent.
REQ-009 err  output  1: one-cycle pulse, UART failed to accept within TIMEOUT.
REQ-010 busy  output  1: high whenever the state is not IDLE.
REQ-011 txdata  output  8: byte presented to the UART; registered.
REQ-012 txclk  output  1: one-cycle load strobe to the UART; registered.
REQ-013 txready  input  1: UART idle and ready (low while transmitting).

Function
REQ-014 States: IDLE, STROBE, WAIT_ACCEPT, WAIT_DONE.
REQ-015 IDLE: if txready=1 and req!=0, pick the winner round-robin, starting at (last winner+1) mod N_REQ; register txdata<=winner byte, grant<=one-hot winner, txclk<=1; go to STROBE.
REQ-016 IDLE with txready=0 or req=0: no change; txclk=0; grant=0.
REQ-017 STROBE lasts exactly one cycle with txclk=1; then txclk<=0; go to WAIT_ACCEPT and clear the timeout counter.
REQ-018 WAIT_ACCEPT: txready=0 -> go to WAIT_DONE. Otherwise increment the counter; when the count reaches TIMEOUT-1 with txready still 1 -> pulse err, clear grant, go to IDLE, no ack.
REQ-019 WAIT_DONE: txready=1 -> pulse ack[winner] for one cycle, clear grant, go to IDLE. No timeout in this state.
REQ-020 The last-winner pointer updates on every completion: ack or err.
REQ-021 A requester that drops req mid-transfer does not abort the transfer; it still receives ack.
REQ-022 New requests arriving during a transfer are evaluated only in IDLE.
REQ-023 The earliest re-grant is the cycle after ack.
REQ-024 txdata holds its value after a transfer until the next load.
REQ-025 Counter width is clog2(TIMEOUT)+1 bits; the counter never wraps.

Reset
REQ-026 Asynchronous assertion (reset=0) forces within the same cycle:
  - state=IDLE
  - txdata=0, txclk=0, grant=0, ack=0, err=0, busy=0
  - counter=0
  - last-winner pointer=N_REQ-1, so requester 0 has first priority
REQ-027 Reset mid-transfer abandons the byte with no ack or err.
REQ-028 Deassertion is taken as synchronised externally; the first active edge after release may grant.

Structure
REQ-029 Package uart_sched_pkg holds:
  - the state enum type
  - default N_REQ and TIMEOUT constants
REQ-030 Sub-module rr_picker: combinational round-robin winner select (req, pointer -> one-hot, index, valid); instantiated once.

Verification
REQ-031 Single request: req=0001, data 0x41, txready drops 2 cycles after txclk and rises 10 cycles later -> txclk is one cycle with txdata=0x41; ack[0] is one cycle exactly one cycle after txready rises.
REQ-032 Fairness: req=1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-033 Timeout: txready held 1 after strobe -> err pulses TIMEOUT cycles after STROBE; no ack; the next grant goes to the next requester.
REQ-034 Busy UART: req=0100 while txready=0 -> no txclk until txready=1, then grant=0100.
REQ-035 Reset mid-WAIT_DONE (reset low for 1 cycle) -> all outputs 0 immediately; a held request is re-granted to requester 0 first.
REQ-036 Request dropped during WAIT_DONE -> ack still pulses for that requester.
